// File: rtl/fp_normalizer.sv
// Post-add/sub normalizer: re-normalizes a raw mantissa sum one bit per cycle
// and adjusts the exponent, flagging zero, overflow (inf) and underflow (denormal).
module fp_normalizer #(
   parameter int EXP_WIDTH = 8,
   parameter int MAN_WIDTH = 24
) (
   input  logic                 clk,
   input  logic                 arst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 sign_in,
   input  logic [EXP_WIDTH-1:0] exp_in,
   input  logic [MAN_WIDTH:0]   man_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 sign_out,
   output logic [EXP_WIDTH-1:0] exp_out,
   output logic [MAN_WIDTH-1:0] man_out,
   output logic [4:0]           shift_count,
   output logic                 zero_flag,
   output logic                 overflow_flag,
   output logic                 underflow_flag
);

   typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

   localparam logic [EXP_WIDTH-1:0] EXP_MAX = '1;
   localparam logic [EXP_WIDTH-1:0] EXP_ONE = EXP_WIDTH'(1);

   state_t                 state;
   logic                   sign_r;
   logic [EXP_WIDTH-1:0]   exp_r;
   logic [MAN_WIDTH:0]     man_r;
   logic [4:0]             cnt_r;
   logic                   zf_r;
   logic                   of_r;
   logic                   uf_r;
   logic [EXP_WIDTH-1:0]   exp_inc;

   function automatic logic [4:0] sat_inc(input logic [4:0] c);
      return (c == 5'd31) ? c : c + 5'd1;
   endfunction

   assign exp_inc = exp_r + EXP_ONE;

   always_ff @(posedge clk) begin
      if (!arst_n) begin
         state          <= IDLE;
         in_ready       <= 1'b0;
         out_valid      <= 1'b0;
         sign_r         <= 1'b0;
         exp_r          <= '0;
         man_r          <= '0;
         cnt_r          <= '0;
         zf_r           <= 1'b0;
         of_r           <= 1'b0;
         uf_r           <= 1'b0;
         sign_out       <= 1'b0;
         exp_out        <= '0;
         man_out        <= '0;
         shift_count    <= '0;
         zero_flag      <= 1'b0;
         overflow_flag  <= 1'b0;
         underflow_flag <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  in_ready <= 1'b0;
                  sign_r   <= sign_in;
                  exp_r    <= exp_in;
                  man_r    <= man_in;
                  cnt_r    <= '0;
                  zf_r     <= 1'b0;
                  of_r     <= 1'b0;
                  uf_r     <= 1'b0;
                  state    <= NORM;
               end else begin
                  in_ready <= 1'b1;
               end
            end
            NORM: begin
               // One decision per cycle; the order of these tests defines the result.
               if (man_r == '0) begin
                  exp_r <= '0;
                  zf_r  <= 1'b1;
                  state <= DONE;
               end else if (man_r[MAN_WIDTH]) begin
                  exp_r <= exp_inc;
                  if (exp_inc == EXP_MAX) begin
                     man_r <= '0;
                     of_r  <= 1'b1;
                  end else begin
                     man_r <= man_r >> 1;
                  end
                  state <= DONE;
               end else if (man_r[MAN_WIDTH-1]) begin
                  state <= DONE;
               end else if (exp_r <= EXP_ONE) begin
                  exp_r <= '0;
                  uf_r  <= 1'b1;
                  state <= DONE;
               end else begin
                  man_r <= man_r << 1;
                  exp_r <= exp_r - EXP_ONE;
                  cnt_r <= sat_inc(cnt_r);
               end
            end
            DONE: begin
               if (!out_valid) begin
                  sign_out       <= sign_r;
                  exp_out        <= exp_r;
                  man_out        <= man_r[MAN_WIDTH-1:0];
                  shift_count    <= cnt_r;
                  zero_flag      <= zf_r;
                  overflow_flag  <= of_r;
                  underflow_flag <= uf_r;
                  out_valid      <= 1'b1;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
